// File: rtl/if_id_fifo_if.sv
// rtl/if_id_fifo_if.sv - fetch-to-decode handshake bundle for the IF/ID instruction queue
interface if_id_fifo_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;
  logic [CNT_W-1:0]  buf_count;

  modport master (
    output if_valid, if_pc, if_inst,
    input  if_ready, id_pc, id_inst, id_valid, buf_count
  );

  modport slave (
    input  if_valid, if_pc, if_inst,
    output if_ready, id_pc, id_inst, id_valid, buf_count
  );
endinterface

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - DEPTH-entry in-order IF/ID queue with registered ID stage, flush and back-pressure
module if_id_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic         flush,
  if_id_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];

  logic ready;
  logic accept;
  logic advance;
  logic empty;
  logic push;
  logic pop;
  logic unused_stall;

  assign unused_stall = ^{stall[5:3], stall[1:0]};

  // Ready looks only at the registered count, so a full queue never takes a push even while popping.
  assign ready   = (count_q < CNT_W'(DEPTH));
  assign accept  = bus.if_valid && ready;
  assign advance = !stall[2];
  assign empty   = (count_q == '0);

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (advance) begin
      if (!empty) begin
        id_pc_d    = mem_pc[rd_ptr_q];
        id_inst_d  = mem_inst[rd_ptr_q];
        id_valid_d = 1'b1;
        pop        = 1'b1;
        push       = accept;
      end else if (accept) begin
        // Bypass only when empty, so queued entries are never overtaken.
        id_pc_d    = bus.if_pc;
        id_inst_d  = bus.if_inst;
        id_valid_d = 1'b1;
      end else begin
        id_pc_d    = '0;
        id_inst_d  = '0;
        id_valid_d = 1'b0;
      end
    end else begin
      push = accept;
    end

    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Storage is deliberately left out of reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]   <= bus.if_pc;
      mem_inst[wr_ptr_q] <= bus.if_inst;
    end
  end

  assign bus.if_ready  = ready;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.buf_count = count_q;
endmodule
